ysyx_22040750_wbu: RTL
======================

# ysyx_22040750_wbu

Writeback stage of the full-pipeline core. Accepts retiring instructions from the MEM stage over a valid/ready handshake, formats load data, selects the writeback source, and holds the result in a single-entry stage register. That register drives the GPR write port and the ID-stage bypass network, and a retire event plus counter are produced for difftest.

## Interface
- `CNT_W`, default 64: width of the retire counter.
- `I_sys_clk`  in  1  core clock; all state updates on rising edge.
- `I_rst_n`  in  1  reset, asynchronous and active-low.
- `I_mem_valid`  in  1  MEM stage presents an instruction.
- `O_wb_ready`  out  1  WBU can accept this cycle.
- `I_mem_pc`  in  64  PC of the presented instruction.
- `I_mem_rd_addr`  in  5  destination register.
- `I_mem_rd_wen`  in  1  instruction writes rd.
- `I_mem_wb_sel`  in  2  writeback source select:
  - 00: ALU result.
  - 01: load data.
  - 10: PC+4.
  - 11: CSR read data.
- `I_mem_alu_res`  in  64  ALU result.
- `I_mem_load_raw`  in  64  aligned doubleword returned by memory.
- `I_mem_funct3`  in  3  load type.
- `I_mem_addr_lo`  in  3  low bits of the load address.
- `I_mem_csr_rdata`  in  64  CSR old value.
- `I_wb_hold`  in  1  freeze commit (debug/difftest halt).
- `O_gpr_wen`  out  1  GPR write enable.
- `O_gpr_rd_addr`  out  5  GPR write address.
- `O_gpr_wr_data`  out  64  GPR write data.
- `O_byp_valid`  out  1  bypass entry valid.
- `O_byp_rd_addr`  out  5  bypass destination register.
- `O_byp_data`  out  64  bypass value.
- `O_commit`  out  1  one-cycle retire pulse.
- `O_commit_pc`  out  64  PC of the retiring instruction.
- `O_retire_cnt`  out  CNT_W  count of retired instructions.

## Operation
- State is a single-entry stage register holding `valid_q`, `pc_q`, `rd_q`, `wen_q` and `data_q`.
- Flow control:
  - `O_wb_ready = !valid_q || !I_wb_hold`.
  - Accept condition: `I_mem_valid && O_wb_ready`.
  - On accept, the entry is loaded with the formatted result and `valid_q` is set to 1.
  - Otherwise, if the entry commits, `valid_q` is cleared to 0.
  - With hold asserted, the entry is unchanged.
- The result is formatted before the register, from `I_mem_wb_sel`:
  - 00: `I_mem_alu_res`.
  - 10: `I_mem_pc + 4`, modulo 2^64.
  - 11: `I_mem_csr_rdata`.
  - 01: load formatting, below.
- Load formatting by `funct3`. Byte lane k = `raw[8k+7:8k]`.
  - 000 lb: lane `addr_lo`, sign-extended.
  - 001 lh: halfword `addr_lo[2:1]`, sign-extended.
  - 010 lw: word `addr_lo[2]`, sign-extended.
  - 011 ld: full 64 bits.
  - 100 lbu, 101 lhu, 110 lwu: as above, zero-extended.
  - 111: result 0.
  - Address bits below the access size are ignored, so misalignment is never flagged here.
- Commit condition: `valid_q && !I_wb_hold`.
  - `O_commit` and `O_commit_pc = pc_q` are driven on commit.
  - `O_retire_cnt` increments at the commit edge and wraps to 0 after 2^CNT_W−1.
- GPR port:
  - `O_gpr_wen = commit && wen_q && (rd_q != 0)`.
  - `O_gpr_rd_addr = rd_q` and `O_gpr_wr_data = data_q`, always driven.
- Bypass:
  - `O_byp_valid = valid_q && wen_q && (rd_q != 0)`.
  - Bypass is independent of hold, because held data has not yet reached the GPR.
  - `O_byp_rd_addr = rd_q`, `O_byp_data = data_q`.
- Accept and commit in the same cycle is legal: the old entry commits and the new entry loads at the same edge. This sustains 1 instruction per cycle.

## Timing
- Reset (asynchronous, `I_rst_n` = 0) forces:
  - `valid_q` = 0, `pc_q` = 0, `rd_q` = 0, `wen_q` = 0, `data_q` = 0, `O_retire_cnt` = 0.
  - Therefore `O_wb_ready` = 1, and `O_gpr_wen`, `O_byp_valid`, `O_commit` are all 0.
  - Data outputs read 0.
- Reset mid-operation discards the entry without committing it and without a GPR write.
- Latency:
  - An instruction accepted at edge N is visible on `O_gpr_*`, `O_byp_*` and `O_commit` during cycle N+1.
  - The GPR captures the value at edge N+1, provided hold is low.
- All outputs are combinational from the stage register and `I_wb_hold`. No path exists from the MEM inputs to the outputs.
- Hold behaviour:
  - Hold asserted with the entry full: ready = 0, the entry persists, and no commit or write occurs.
  - On hold release, the entry commits in that same cycle.
  - Hold asserted with the entry empty: ready = 1, one instruction is accepted, and ready then drops.

## Test plan
- Reset, then ALU writeback:
  - Stimulus: `I_rst_n` = 0, then 1. Present valid, rd = 5, wen = 1, sel = 00, alu = 0x1234.
  - Response: next cycle `O_gpr_wen` = 1, addr = 5, data = 0x1234, `O_commit` = 1. `O_retire_cnt` goes 0 → 1.
- Load formatting:
  - Stimulus: raw = 0x8877_6655_4433_2281.
  - Responses:
    - lb, addr_lo = 0 → 0xFFFF_FFFF_FFFF_FF81.
    - lbu, addr_lo = 7 → 0x88.
    - lh, addr_lo = 6 → 0xFFFF_FFFF_FFFF_8877.
    - lwu, addr_lo = 4 → 0x8877_6655.
    - ld → raw.
- x0 protection:
  - Stimulus: rd = 0, wen = 1, alu = 0xDEAD.
  - Response: `O_commit` = 1, `O_gpr_wen` = 0, `O_byp_valid` = 0.
- Back-to-back plus JAL:
  - Stimulus: 3 consecutive valid instructions, the middle one sel = 10 with pc = 0x8000_0000.
  - Response: ready stays 1, three consecutive commits, the middle one writes 0x8000_0004, `O_retire_cnt` = 3.
- Hold:
  - Stimulus: entry full, `I_wb_hold` = 1 for 4 cycles while MEM holds valid.
  - Response: ready = 0, no commit, `O_byp_valid` stays 1 with the held data. On release: commit plus accept in the same cycle.
- Async reset mid-stream:
  - Stimulus: assert `I_rst_n` = 0 between edges with the entry valid.
  - Response: outputs go to reset values immediately, no GPR write, `O_retire_cnt` = 0.

Source files
------------

// File: rtl/ysyx_22040750_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_22040750_wbu -- writeback stage.
//
// Takes retiring instructions from MEM over valid/ready. It formats the load
// data, selects the writeback source and keeps the result in a single-entry
// stage register. That register drives the GPR write port and the ID bypass.
// It also produces a retire pulse and a retire counter for difftest.
//
// Ports
//   I_sys_clk, I_rst_n    clock and asynchronous active-low reset
//   I_mem_valid/O_wb_ready   handshake with MEM
//   I_mem_*               instruction fields and data from MEM
//   I_wb_hold             freezes commit (debug / difftest halt)
//   O_gpr_*               GPR write port
//   O_byp_*               bypass entry toward ID
//   O_commit/_pc          one-cycle retire pulse and its PC
//   O_retire_cnt          number of retired instructions (wraps)
//
// Every output is a function of the stage register and I_wb_hold only.
// No path exists from the MEM inputs to the outputs.
// ----------------------------------------------------------------------------
module ysyx_22040750_wbu #(
    parameter int CNT_W = 64
) (
    input  logic             I_sys_clk,
    input  logic             I_rst_n,
    input  logic             I_mem_valid,
    output logic             O_wb_ready,
    input  logic [63:0]      I_mem_pc,
    input  logic [4:0]       I_mem_rd_addr,
    input  logic             I_mem_rd_wen,
    input  logic [1:0]       I_mem_wb_sel,
    input  logic [63:0]      I_mem_alu_res,
    input  logic [63:0]      I_mem_load_raw,
    input  logic [2:0]       I_mem_funct3,
    input  logic [2:0]       I_mem_addr_lo,
    input  logic [63:0]      I_mem_csr_rdata,
    input  logic             I_wb_hold,
    output logic             O_gpr_wen,
    output logic [4:0]       O_gpr_rd_addr,
    output logic [63:0]      O_gpr_wr_data,
    output logic             O_byp_valid,
    output logic [4:0]       O_byp_rd_addr,
    output logic [63:0]      O_byp_data,
    output logic             O_commit,
    output logic [63:0]      O_commit_pc,
    output logic [CNT_W-1:0] O_retire_cnt
);

    logic             r_valid;
    logic [63:0]      r_pc;
    logic [4:0]       r_rd;
    logic             r_wen;
    logic [63:0]      r_data;
    logic [CNT_W-1:0] r_cnt;

    logic             w_ready;
    logic             w_accept;
    logic             w_commit;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_word;
    logic [63:0]      w_load;
    logic [63:0]      w_result;

    assign w_ready  = !r_valid || !I_wb_hold;
    assign w_accept = I_mem_valid && w_ready;
    assign w_commit = r_valid && !I_wb_hold;

    // The lane pick uses only the address bits at or above the access size.
    // A misaligned address therefore selects its naturally aligned container.
    assign w_byte = I_mem_load_raw[{I_mem_addr_lo, 3'b000} +: 8];
    assign w_half = I_mem_load_raw[{I_mem_addr_lo[2:1], 4'b0000} +: 16];
    assign w_word = I_mem_load_raw[{I_mem_addr_lo[2], 5'b00000} +: 32];

    always_comb begin
        w_load = 64'd0;
        case (I_mem_funct3)
            3'b000:  w_load = {{56{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{48{w_half[15]}}, w_half};
            3'b010:  w_load = {{32{w_word[31]}}, w_word};
            3'b011:  w_load = I_mem_load_raw;
            3'b100:  w_load = {56'd0, w_byte};
            3'b101:  w_load = {48'd0, w_half};
            3'b110:  w_load = {32'd0, w_word};
            default: w_load = 64'd0;
        endcase
    end

    always_comb begin
        w_result = I_mem_alu_res;
        case (I_mem_wb_sel)
            2'b00: w_result = I_mem_alu_res;
            2'b01: w_result = w_load;
            2'b10: w_result = I_mem_pc + 64'd4;
            2'b11: w_result = I_mem_csr_rdata;
            default: w_result = I_mem_alu_res;
        endcase
    end

    // When accept and commit happen together, the new entry simply overwrites
    // the committing one. This is what sustains one instruction per cycle.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= 64'd0;
            r_rd    <= 5'd0;
            r_wen   <= 1'b0;
            r_data  <= 64'd0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= I_mem_pc;
            r_rd    <= I_mem_rd_addr;
            r_wen   <= I_mem_rd_wen;
            r_data  <= w_result;
        end else if (w_commit) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            r_cnt <= '0;
        else if (w_commit)
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign O_wb_ready    = w_ready;
    assign O_commit      = w_commit;
    assign O_commit_pc   = r_pc;
    assign O_retire_cnt  = r_cnt;
    assign O_gpr_wen     = w_commit && r_wen && (r_rd != 5'd0);
    assign O_gpr_rd_addr = r_rd;
    assign O_gpr_wr_data = r_data;
    // The bypass ignores hold: a held result has not reached the GPR yet.
    assign O_byp_valid   = r_valid && r_wen && (r_rd != 5'd0);
    assign O_byp_rd_addr = r_rd;
    assign O_byp_data    = r_data;

endmodule
